display_frame_seq: RTL and testbench

// - Sequential, parametrised display generator: turns a segment message into NB_FRAMES randomised pixel frames.
// - Each frame lights message segments plus LFSR-chosen noise segments, then streams the frame one row per beat.
// - Output uses a valid/ready handshake. Sits between the garbler-side message registers and the pixel consumer.

---
 rtl/display_pkg.sv | 19 +
 rtl/display_lfsr.sv | 35 +++
 rtl/segment2pixel.sv | 16 +
 rtl/display_frame_seq.sv | 163 ++++++++++++++++
 tb/tb_display_frame_seq.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared types and helpers for the display frame sequencer: FSM states,
// default Galois LFSR feedback masks and the single-step LFSR function.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    STREAM  = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

  // Galois right-shift step; callers zero-extend narrower states (up to 32 bits).
  function automatic logic [31:0] lfsr_next(input logic [31:0] s, input logic [31:0] taps);
    lfsr_next = s[0] ? ((s >> 1) ^ taps) : (s >> 1);
  endfunction

endpackage

// File: rtl/display_lfsr.sv
// Galois LFSR with synchronous load and step. A zero seed would lock the
// register at zero forever, so it is loaded as 1 instead.
module display_lfsr
  import display_pkg::*;
#(
  parameter int                 RNDSIZE   = 16,
  parameter logic [RNDSIZE-1:0] LFSR_TAPS = RNDSIZE'(LFSR_TAPS_16)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [RNDSIZE-1:0] seed_i,
  output logic [RNDSIZE-1:0] state_o
);

  logic [RNDSIZE-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = (seed_i == '0) ? RNDSIZE'(1) : seed_i;
    end else if (step_i) begin
      state_d = RNDSIZE'(lfsr_next(32'(state_q), 32'(LFSR_TAPS)));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= RNDSIZE'(1);
    else       state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/segment2pixel.sv
// Segment-to-pixel bitmap mapping: every pixel belongs to exactly one segment,
// segments interleave across the raster (pixel p is driven by segment p mod NB_SEGMENTS).
module segment2pixel #(
  parameter int WIDTH       = 120,
  parameter int HEIGHT      = 52,
  parameter int NB_SEGMENTS = 28
) (
  input  logic [NB_SEGMENTS-1:0]  seg_i,
  output logic [WIDTH*HEIGHT-1:0] pix_o
);

  for (genvar p = 0; p < WIDTH*HEIGHT; p++) begin : g_pix
    assign pix_o[p] = seg_i[p % NB_SEGMENTS];
  end

endmodule

// File: rtl/display_frame_seq.sv
// Randomised display generator: NB_FRAMES frames of message + LFSR noise segments,
// streamed one row per valid/ready beat. Optional XOR watermark: DISPLAY_WATERMARK_EN.
module display_frame_seq
  import display_pkg::*;
#(
  parameter int                 WIDTH       = 120,
  parameter int                 HEIGHT      = 52,
  parameter int                 NB_SEGMENTS = 28,
  parameter int                 RNDSIZE     = 16,
  parameter logic [RNDSIZE-1:0] LFSR_TAPS   = RNDSIZE'(LFSR_TAPS_16),
  parameter int                 NB_FRAMES   = 4,
  parameter int                 PROB_SEL    = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  output logic                    start_ready_o,
  input  logic [NB_SEGMENTS-1:0]  msg_i,
  input  logic                    noise_en_i,
  input  logic [RNDSIZE-1:0]      seed_i,
`ifdef DISPLAY_WATERMARK_EN
  input  logic [WIDTH*HEIGHT-1:0] watmk_i,
`endif
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [WIDTH-1:0]        out_row_o,
  output logic                    row_last_o,
  output logic                    frame_last_o,
  output logic                    done_o
);

  localparam int             RW      = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int             FW      = $clog2(NB_FRAMES + 1);
  localparam logic [RW-1:0]  ROW_MAX = RW'(HEIGHT - 1);
  localparam logic [FW-1:0]  FRM_MAX = FW'(NB_FRAMES - 1);
  localparam logic [1:0]     PSEL    = 2'(PROB_SEL);

  state_e                         state_q, state_d;
  logic [RW-1:0]                  row_q, row_d;
  logic [FW-1:0]                  frm_q, frm_d;
  logic                           done_q, done_d;
  logic [NB_SEGMENTS-1:0]         msg_q;
  logic                           noise_q;
  logic [HEIGHT-1:0][WIDTH-1:0]   frame_q;
  logic                           lfsr_load, lfsr_step;
  logic [RNDSIZE-1:0]             lfsr_s;
  logic [NB_SEGMENTS-1:0]         selseg;
  logic [WIDTH*HEIGHT-1:0]        pix, frame_nx;

  display_lfsr #(
    .RNDSIZE   (RNDSIZE),
    .LFSR_TAPS (LFSR_TAPS)
  ) u_lfsr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (lfsr_load),
    .step_i  (lfsr_step),
    .seed_i  (seed_i),
    .state_o (lfsr_s)
  );

  // Each segment draws a 2-bit random value from adjacent LFSR bits; it is lit
  // as noise when that value is <= PSEL, i.e. with probability (PSEL+1)/4.
  for (genvar i = 0; i < NB_SEGMENTS; i++) begin : g_sel
    logic [1:0] r;
    assign r         = {lfsr_s[(2*i+1) % RNDSIZE], lfsr_s[(2*i) % RNDSIZE]};
    assign selseg[i] = msg_q[i] | (noise_q & (r <= PSEL));
  end

  segment2pixel #(
    .WIDTH       (WIDTH),
    .HEIGHT      (HEIGHT),
    .NB_SEGMENTS (NB_SEGMENTS)
  ) u_s2p (
    .seg_i (selseg),
    .pix_o (pix)
  );

`ifdef DISPLAY_WATERMARK_EN
  logic [WIDTH*HEIGHT-1:0] watmk_q;

  always_ff @(posedge clk_i) begin
    if (rst_i)                                watmk_q <= '0;
    else if (start_i && (state_q == IDLE))    watmk_q <= watmk_i;
  end

  assign frame_nx = pix ^ watmk_q;
`else
  assign frame_nx = pix;
`endif

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    frm_d     = frm_q;
    done_d    = 1'b0;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = COMPUTE;
          lfsr_load = 1'b1;
          row_d     = '0;
          frm_d     = '0;
        end
      end
      COMPUTE: begin
        lfsr_step = 1'b1;
        row_d     = '0;
        state_d   = STREAM;
      end
      STREAM: begin
        if (out_ready_i) begin
          if (row_q == ROW_MAX) begin
            row_d = '0;
            if (frm_q == FRM_MAX) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              frm_d   = frm_q + FW'(1);
              state_d = COMPUTE;
            end
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      row_q   <= '0;
      frm_q   <= '0;
      done_q  <= 1'b0;
      msg_q   <= '0;
      noise_q <= 1'b0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      frm_q   <= frm_d;
      done_q  <= done_d;
      if (start_i && (state_q == IDLE)) begin
        msg_q   <= msg_i;
        noise_q <= noise_en_i;
      end
      if (state_q == COMPUTE) frame_q <= frame_nx;
    end
  end

  // Row data is gated so the bus reads zero outside STREAM.
  assign start_ready_o = (state_q == IDLE);
  assign out_valid_o   = (state_q == STREAM);
  assign out_row_o     = out_valid_o ? frame_q[row_q] : '0;
  assign row_last_o    = out_valid_o && (row_q == ROW_MAX);
  assign frame_last_o  = row_last_o && (frm_q == FRM_MAX);
  assign done_o        = done_q;

endmodule

// File: tb/tb_display_frame_seq.sv
// Scoreboard bench for display_frame_seq: expected row beats are pushed when a job
// starts and popped as the DUT hands them over; a second instance covers PROB_SEL=3.
module tb_display_frame_seq;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int NS = 7;
  localparam int RS = 16;
  localparam int NF = 2;
  localparam int PS = 0;

  logic          clk = 1'b0;
  logic          rst, start, noise_en, out_ready, toggle;
  logic [NS-1:0] msg;
  logic [RS-1:0] seed;
  logic [W*H-1:0] watmk, watmk_r;
  logic          start_ready, out_valid, row_last, frame_last, done;
  logic [W-1:0]  out_row;

  logic          start3, start_ready3, out_valid3, row_last3, frame_last3, done3;
  logic [W-1:0]  out_row3;

  int            n_chk = 0, n_pass = 0, beats = 0;
  logic [W+1:0]  sb[$];
  logic          exp_done = 1'b0, hold_pend = 1'b0;
  logic [W+1:0]  held, e;

  always #5 clk = ~clk;

  display_frame_seq #(
    .WIDTH(W), .HEIGHT(H), .NB_SEGMENTS(NS), .RNDSIZE(RS),
    .LFSR_TAPS(16'hB400), .NB_FRAMES(NF), .PROB_SEL(PS)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .start_ready_o(start_ready),
    .msg_i(msg), .noise_en_i(noise_en), .seed_i(seed),
`ifdef DISPLAY_WATERMARK_EN
    .watmk_i(watmk),
`endif
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_row_o(out_row),
    .row_last_o(row_last), .frame_last_o(frame_last), .done_o(done)
  );

  display_frame_seq #(
    .WIDTH(W), .HEIGHT(H), .NB_SEGMENTS(NS), .RNDSIZE(RS),
    .LFSR_TAPS(16'hB400), .NB_FRAMES(NF), .PROB_SEL(3)
  ) u_p3 (
    .clk_i(clk), .rst_i(rst), .start_i(start3), .start_ready_o(start_ready3),
    .msg_i(msg), .noise_en_i(noise_en), .seed_i(seed),
`ifdef DISPLAY_WATERMARK_EN
    .watmk_i(watmk),
`endif
    .out_valid_o(out_valid3), .out_ready_i(1'b1), .out_row_o(out_row3),
    .row_last_o(row_last3), .frame_last_o(frame_last3), .done_o(done3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: per frame pick segments from the LFSR, map to pixels, queue rows.
  task automatic push_job(input logic [NS-1:0] m, input logic ne, input logic [RS-1:0] sd);
    logic [RS-1:0]  s;
    logic [NS-1:0]  sel;
    logic [W*H-1:0] px;
    logic [1:0]     r;
    s = (sd == '0) ? 16'h0001 : sd;
    for (int f = 0; f < NF; f++) begin
      for (int i = 0; i < NS; i++) begin
        r      = {s[(2*i+1) % RS], s[(2*i) % RS]};
        sel[i] = m[i] | (ne && (int'(r) <= PS));
      end
      for (int p = 0; p < W*H; p++) px[p] = sel[p % NS];
`ifdef DISPLAY_WATERMARK_EN
      px = px ^ watmk_r;
`endif
      for (int rw = 0; rw < H; rw++)
        sb.push_back({px[rw*W +: W], (rw == H-1), (rw == H-1) && (f == NF-1)});
      s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    end
  endtask

  task automatic run_job(input logic [NS-1:0] m, input logic ne, input logic [RS-1:0] sd);
    int t = 0;
    while (!start_ready && t < 200) begin @(posedge clk); #1; t++; end
    chk("start_ready_wait", 32'(start_ready), 1);
    msg = m; noise_en = ne; seed = sd; start = 1'b1;
    push_job(m, ne, sd);
    beats = 0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("lat_t1_valid", 32'(out_valid), 0);
    chk("lat_t1_ready", 32'(start_ready), 0);
    @(posedge clk); #1;
    chk("lat_t2_valid", 32'(out_valid), 1);
  endtask

  task automatic wait_job;
    int t = 0;
    while (!(start_ready && sb.size() == 0) && t < 400) begin @(posedge clk); #1; t++; end
    chk("job_end", 32'(start_ready && sb.size() == 0), 1);
    chk("beat_count", 32'(beats), NF*H);
  endtask

  initial forever begin
    @(posedge clk); #1;
    if (toggle) out_ready = ~out_ready;
  end

  // Monitor: pop on accepted beats, check hold under backpressure and done timing.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("done", 32'(done), 32'(exp_done));
      exp_done = 1'b0;
      if (out_valid) begin
        if (hold_pend) chk("hold", 32'({out_row, row_last, frame_last}), 32'(held));
        if (out_ready) begin
          if (sb.size() == 0) chk("sb_underflow", 1, 0);
          else begin
            e = sb.pop_front();
            chk("beat", 32'({out_row, row_last, frame_last}), 32'(e));
            if (e[0]) exp_done = 1'b1;
          end
          beats++;
          hold_pend = 1'b0;
        end else begin
          hold_pend = 1'b1;
          held      = {out_row, row_last, frame_last};
        end
      end else hold_pend = 1'b0;
    end else begin
      hold_pend = 1'b0;
      exp_done  = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t, c3;
    rst = 1'b1; start = 1'b0; start3 = 1'b0; noise_en = 1'b0; msg = '0; seed = '0;
    out_ready = 1'b1; toggle = 1'b0; watmk_r = '0; watmk = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_start_ready", 32'(start_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_row", 32'(out_row), 0);
    chk("rst_row_last", 32'(row_last), 0);
    chk("rst_frame_last", 32'(frame_last), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full message, no noise: every row lit
    run_job(7'h7F, 1'b0, 16'hACE1);
    chk("full_row0", 32'(out_row), 32'hFF);
    wait_job();

    // Zero seed loads as 1: frame 0 selseg = 7'h7E -> row 0 = 8'h7E
    run_job(7'h00, 1'b1, 16'h0000);
    chk("seed0_row0", 32'(out_row), 32'h7E);
    wait_job();

    // Backpressure toggling every cycle
    toggle = 1'b1;
    run_job(7'h2D, 1'b1, 16'h1234);
    wait_job();
    run_job(7'h00, 1'b1, 16'h9A3C);
    wait_job();
    toggle = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;

    // Start pulsed mid-stream is ignored
    run_job(7'h55, 1'b0, 16'h0F0F);
    repeat (2) @(posedge clk); #1;
    msg = 7'h2A; start = 1'b1;
    chk("midstream_ready", 32'(start_ready), 0);
    @(posedge clk); #1;
    start = 1'b0;
    wait_job();
    run_job(7'h2A, 1'b1, 16'hBEEF);
    wait_job();

    // Reset on beat 3 drops the job without a done pulse
    run_job(7'h3C, 1'b1, 16'h5A5A);
    t = 0;
    while (beats < 2 && t < 50) begin @(posedge clk); #1; t++; end
    chk("rst_mid_reach", 32'(beats >= 2), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_valid", 32'(out_valid), 0);
    chk("rst_mid_ready", 32'(start_ready), 1);
    rst = 1'b0;
    sb.delete();
    repeat (3) @(posedge clk); #1;
    run_job(7'h13, 1'b1, 16'h0001);
    wait_job();

    // PROB_SEL=3 instance lights every segment regardless of LFSR
    msg = '0; noise_en = 1'b1; seed = 16'hCAFE; start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    c3 = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid3) begin
        chk("p3_row", 32'(out_row3), 32'hFF);
        c3++;
      end
    end
    chk("p3_beats", 32'(c3), NF*H);

`ifdef DISPLAY_WATERMARK_EN
    @(posedge clk); #1;
    watmk_r = '1; watmk = watmk_r;
    run_job(7'h00, 1'b0, 16'h0001);
    chk("wm_row0", 32'(out_row), 32'hFF);
    wait_job();
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
